// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame receiver.
// Parity stage is built only when SERIAL_FRAME_RX_PARITY_EN is defined.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2
    } state_t;

    localparam int           DEF_SYNC_W    = 8;
    localparam logic [7:0]   DEF_SYNC_WORD = 8'hA5;
    localparam int           PAR_MAX_W     = 64;

    // True when the vector holds an even number of ones.
    function automatic logic even_ok(input logic [PAR_MAX_W-1:0] v);
        return ~(^v);
    endfunction

endpackage

// File: rtl/serial_frame_rx_sync_window.sv
// Shift window that flags a match on the value it is about to hold.
// Clear has priority over shift; match only asserts on shifting edges.
module sync_window
    import serial_frame_pkg::*;
#(
    parameter int           W       = DEF_SYNC_W,
    parameter logic [W-1:0] PATTERN = DEF_SYNC_WORD
) (
    input  logic clk,
    input  logic reset,
    input  logic shift,
    input  logic clear,
    input  logic data_in,
    output logic match
);

    logic [W-1:0] win;
    logic [W-1:0] win_nxt;

    assign win_nxt = {win[W-2:0], data_in};
    assign match   = shift && (win_nxt == PATTERN);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            win <= '0;
        end else if (shift) begin
            win <= win_nxt;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial byte receiver: sync hunt, MSB-first payload, optional
// even parity (SERIAL_FRAME_RX_PARITY_EN).
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int                SYNC_W    = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter int                DATA_W    = 8,
    parameter int                CNT_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              err,
    output logic              locked,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int BW = $clog2(DATA_W);

    if (SYNC_WORD == '0) begin : g_bad_sync
        $error("SYNC_WORD must be nonzero");
    end

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] payload;
    logic [DATA_W-1:0] payload_nxt;
    logic [BW-1:0]     bit_cnt;
    logic              match;
    logic              win_shift;
    logic              win_clr;
    logic              last_bit;
    logic              complete;
    logic              fail;

    assign payload_nxt = {payload[DATA_W-2:0], data_in};
    assign last_bit    = (bit_cnt == BW'(DATA_W - 1));

    sync_window #(
        .W       (SYNC_W),
        .PATTERN (SYNC_WORD)
    ) u_win (
        .clk     (clk),
        .reset   (reset),
        .shift   (win_shift),
        .clear   (win_clr),
        .data_in (data_in),
        .match   (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            unique case (state)
                HUNT: if (match) state_nxt = PAYLOAD;
                PAYLOAD: begin
                    if (last_bit) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = HUNT;
`endif
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic par_ok;
    assign par_ok = even_ok(PAR_MAX_W'({payload, data_in}));
`endif

    always_comb begin
        locked    = (state != HUNT);
        win_shift = en && (state == HUNT);
        // Window stays cleared for the whole body so payload never syncs.
        win_clr   = en && ((state != HUNT) || match);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        complete  = en && (state == PARITY) && par_ok;
        fail      = en && (state == PARITY) && !par_ok;
`else
        complete  = en && (state == PAYLOAD) && last_bit;
        fail      = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            payload   <= '0;
            bit_cnt   <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            valid <= complete;
            if (en && state == PAYLOAD) begin
                payload <= payload_nxt;
                bit_cnt <= bit_cnt + 1'b1;
            end else if (en) begin
                bit_cnt <= '0;
            end
            if (complete) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                data_out <= payload;
`else
                data_out <= payload_nxt;
`endif
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= fail;
        end
    end
`else
    logic unused_fail;
    assign unused_fail = fail;
    assign err = 1'b0;
`endif

endmodule
